// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
// Holds the next-PC command encoding and the command field width.
package pc_pkg;

    localparam int unsigned CMD_W = 3;

    localparam logic [CMD_W-1:0] CMD_NEXT   = 3'd0;
    localparam logic [CMD_W-1:0] CMD_JUMP   = 3'd1;
    localparam logic [CMD_W-1:0] CMD_BRANCH = 3'd2;
    localparam logic [CMD_W-1:0] CMD_CALL   = 3'd3;
    localparam logic [CMD_W-1:0] CMD_RET    = 3'd4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and an entry count.
// A push onto a full stack overwrites the oldest entry, so the newest RAS_DEPTH
// addresses stay in LIFO order. A pop of an empty stack leaves the state unchanged.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   push_i, pop_i   stack operations (mutually exclusive in use; push wins)
//   push_data_i     address to push
//   top_c_o         current top entry (valid when not empty)
//   count_o         number of valid entries (registered)
//   full_o, empty_o registered status
//   ovf_c_o         push while full this cycle
//   unf_c_o         pop while empty this cycle
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push_i,
    input  logic                               pop_i,
    input  logic [ADDR_W-1:0]                  push_data_i,
    output logic [ADDR_W-1:0]                  top_c_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     count_o,
    output logic                               full_o,
    output logic                               empty_o,
    output logic                               ovf_c_o,
    output logic                               unf_c_o
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full_q, empty_q;

    // ptr_q points at the next free slot; the top entry sits one below it.
    always_comb begin
        ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        ptr_dec = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_c_o = 1'b0;
        unf_c_o = 1'b0;
        if (push_i) begin
            ptr_d = ptr_inc;
            if (full_q) begin
                ovf_c_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i) begin
            if (empty_q) begin
                unf_c_o = 1'b1;
            end else begin
                ptr_d = ptr_dec;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Pointer, count and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(RAS_DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    // Storage needs no reset; entries are only read once pushed.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

    assign top_c_o = mem_q[ptr_dec];
    assign count_o = cnt_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: increment, jump, relative branch and
// call/return through an internal return-address stack with sticky error flags.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   stall             hold PC and stack, command ignored
//   cmd               NEXT/JUMP/BRANCH/CALL/RET, other codes hold
//   target, offset    absolute destination, signed branch displacement
//   err_clr           clears the sticky flags (an error in the same cycle wins)
//   pc                registered program counter
//   ras_count/full/empty  stack occupancy
//   ras_ovf, ras_unf  sticky overflow / underflow
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned OFF_W     = 8,
    parameter int unsigned STEP      = 1,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_VEC = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           stall,
    input  logic [CMD_W-1:0]               cmd,
    input  logic [ADDR_W-1:0]              target,
    input  logic [OFF_W-1:0]               offset,
    input  logic                           err_clr,
    output logic [ADDR_W-1:0]              pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_full,
    output logic                           ras_empty,
    output logic                           ras_ovf,
    output logic                           ras_unf
);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, off_ext, ras_top;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              push_c, pop_c, ovf_evt_c, unf_evt_c, empty_c;

    assign pc_inc  = pc_q + ADDR_W'(STEP);
    assign off_ext = ADDR_W'($signed(offset));

    // Next-PC mux and stack requests; a stall masks the command entirely.
    always_comb begin
        pc_d   = pc_q;
        push_c = 1'b0;
        pop_c  = 1'b0;
        if (!stall) begin
            case (cmd)
                CMD_NEXT:   pc_d = pc_inc;
                CMD_JUMP:   pc_d = target;
                CMD_BRANCH: pc_d = pc_q + off_ext;
                CMD_CALL: begin
                    push_c = 1'b1;
                    pc_d   = target;
                end
                CMD_RET: begin
                    pop_c = 1'b1;
                    pc_d  = empty_c ? pc_inc : ras_top;
                end
                default:    pc_d = pc_q;
            endcase
        end
        ovf_d = ovf_evt_c | (ovf_q & ~err_clr);
        unf_d = unf_evt_c | (unf_q & ~err_clr);
    end

    // PC and sticky flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= ADDR_W'(RESET_VEC);
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_c),
        .pop_i       (pop_c),
        .push_data_i (pc_inc),
        .top_c_o     (ras_top),
        .count_o     (ras_count),
        .full_o      (ras_full),
        .empty_o     (empty_c),
        .ovf_c_o     (ovf_evt_c),
        .unf_c_o     (unf_evt_c)
    );

    assign pc        = pc_q;
    assign ras_empty = empty_c;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed test-plan scenarios followed by
// randomized commands checked against a queue-based behavioural model.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  cmd;
    logic [11:0] target;
    logic [7:0]  offset;
    logic        err_clr;
    logic [11:0] pc;
    logic [2:0]  ras_count;
    logic        ras_full, ras_empty, ras_ovf, ras_unf;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [11:0] m_pc;
    logic [11:0] m_ras[$];
    logic        m_ovf, m_unf;

    pc_sequencer #(
        .ADDR_W    (12),
        .OFF_W     (8),
        .STEP      (1),
        .RAS_DEPTH (4),
        .RESET_VEC (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .cmd       (cmd),
        .target    (target),
        .offset    (offset),
        .err_clr   (err_clr),
        .pc        (pc),
        .ras_count (ras_count),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model, sample after the edge.
    task automatic step(input logic r, input logic s, input logic [2:0] c,
                        input logic [11:0] t, input logic [7:0] o, input logic e);
        logic ov, un;
        rst_n = r; stall = s; cmd = c; target = t; offset = o; err_clr = e;
        @(posedge clk);
        #1;
        if (!r) begin
            m_pc = 12'h000;
            m_ras.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            ov = 1'b0;
            un = 1'b0;
            if (!s) begin
                case (c)
                    3'd0: m_pc = m_pc + 12'd1;
                    3'd1: m_pc = t;
                    3'd2: m_pc = m_pc + {{4{o[7]}}, o};
                    3'd3: begin
                        m_ras.push_back(m_pc + 12'd1);
                        if (m_ras.size() > 4) begin
                            void'(m_ras.pop_front());
                            ov = 1'b1;
                        end
                        m_pc = t;
                    end
                    3'd4: begin
                        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                        else begin
                            m_pc = m_pc + 12'd1;
                            un = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            m_ovf = ov | (m_ovf & ~e);
            m_unf = un | (m_unf & ~e);
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 3'd0, 12'h0, 8'h0, 1'b0);
        n_tests++;
        if (pc !== 12'h000 || ras_count !== 3'd0 || ras_empty !== 1'b1 ||
            ras_full !== 1'b0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: pc=%h cnt=%0d e=%b f=%b o=%b u=%b, expected 000 0 1 0 0 0",
                     pc, ras_count, ras_empty, ras_full, ras_ovf, ras_unf);
        end
    endtask

    task automatic test_next_stall();
        logic [11:0] exp_pc [6] = '{12'h001, 12'h002, 12'h003, 12'h003, 12'h003, 12'h004};
        logic        stl    [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, stl[i], 3'd0, 12'h0, 8'h0, 1'b0);
            n_tests++;
            if (pc !== exp_pc[i]) begin
                n_fail++;
                $display("FAIL next_stall[%0d]: pc=%h expected %h", i, pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_wrap_branch();
        logic [2:0]  cmds   [5] = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd2};
        logic [11:0] exp_pc [5] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'hFFF};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, cmds[i], 12'hFFE, 8'hFE, 1'b0);
            n_tests++;
            if (pc !== exp_pc[i]) begin
                n_fail++;
                $display("FAIL wrap_branch[%0d]: pc=%h expected %h", i, pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_call_ret();
        logic [2:0]  cmds   [4] = '{3'd3, 3'd3, 3'd4, 3'd4};
        logic [11:0] tgts   [4] = '{12'h100, 12'h200, 12'h000, 12'h000};
        logic [11:0] exp_pc [4] = '{12'h100, 12'h200, 12'h101, 12'h011};
        logic [2:0]  exp_c  [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
        step(1'b1, 1'b0, 3'd1, 12'h010, 8'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, cmds[i], tgts[i], 8'h0, 1'b0);
            n_tests++;
            if (pc !== exp_pc[i] || ras_count !== exp_c[i]) begin
                n_fail++;
                $display("FAIL call_ret[%0d]: pc=%h cnt=%0d expected %h %0d",
                         i, pc, ras_count, exp_pc[i], exp_c[i]);
            end
        end
        n_tests++;
        if (ras_empty !== 1'b1 || ras_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL call_ret_empty: empty=%b unf=%b expected 1 0", ras_empty, ras_unf);
        end
    endtask

    task automatic test_overflow();
        logic [11:0] exp_pc [5] = '{12'h041, 12'h031, 12'h021, 12'h011, 12'h012};
        step(1'b0, 1'b0, 3'd0, 12'h0, 8'h0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 3'd3, 12'(i * 16), 8'h0, 1'b0);
        end
        n_tests++;
        if (ras_ovf !== 1'b1 || ras_count !== 3'd4 || ras_full !== 1'b1 || pc !== 12'h050) begin
            n_fail++;
            $display("FAIL overflow: ovf=%b cnt=%0d full=%b pc=%h expected 1 4 1 050",
                     ras_ovf, ras_count, ras_full, pc);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 3'd4, 12'h0, 8'h0, 1'b0);
            n_tests++;
            if (pc !== exp_pc[i]) begin
                n_fail++;
                $display("FAIL overflow_ret[%0d]: pc=%h expected %h", i, pc, exp_pc[i]);
            end
        end
        n_tests++;
        if (ras_unf !== 1'b1 || ras_count !== 3'd0) begin
            n_fail++;
            $display("FAIL underflow: unf=%b cnt=%0d expected 1 0", ras_unf, ras_count);
        end
    endtask

    task automatic test_errclr();
        step(1'b1, 1'b0, 3'd4, 12'h0, 8'h0, 1'b1);
        n_tests++;
        if (ras_unf !== 1'b1 || ras_ovf !== 1'b0 || pc !== 12'h013) begin
            n_fail++;
            $display("FAIL errclr_setwins: unf=%b ovf=%b pc=%h expected 1 0 013", ras_unf, ras_ovf, pc);
        end
        step(1'b1, 1'b1, 3'd0, 12'h0, 8'h0, 1'b1);
        n_tests++;
        if (ras_unf !== 1'b0 || pc !== 12'h013) begin
            n_fail++;
            $display("FAIL errclr_clear: unf=%b pc=%h expected 0 013", ras_unf, pc);
        end
    endtask

    task automatic test_midchain_reset();
        step(1'b1, 1'b0, 3'd3, 12'h100, 8'h0, 1'b0);
        step(1'b1, 1'b0, 3'd3, 12'h200, 8'h0, 1'b0);
        step(1'b0, 1'b0, 3'd3, 12'h300, 8'h0, 1'b0);
        n_tests++;
        if (pc !== 12'h000 || ras_count !== 3'd0 || ras_empty !== 1'b1 ||
            ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL midchain_reset: pc=%h cnt=%0d e=%b o=%b u=%b expected 000 0 1 0 0",
                     pc, ras_count, ras_empty, ras_ovf, ras_unf);
        end
        step(1'b1, 1'b0, 3'd4, 12'h0, 8'h0, 1'b0);
        n_tests++;
        if (pc !== 12'h001 || ras_unf !== 1'b1) begin
            n_fail++;
            $display("FAIL midchain_ret: pc=%h unf=%b expected 001 1", pc, ras_unf);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, 3'd3, 12'h7A0, 8'h0, 1'b0);
        step(1'b1, 1'b0, 3'd4, 12'h0, 8'h0, 1'b0);
        n_tests++;
        if (pc !== 12'h002) begin
            n_fail++;
            $display("FAIL back_to_back: pc=%h expected 002", pc);
        end
    endtask

    task automatic test_random();
        logic       r, s, e;
        logic [2:0] c;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) != 0);
            s = ($urandom_range(0, 4) == 0);
            e = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(5, 7) & 7)
                                            : 3'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) c = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'd4;
            step(r, s, c, 12'($urandom), 8'($urandom), e);
            n_tests++;
            if (pc !== m_pc || ras_count !== 3'(m_ras.size()) ||
                ras_full !== (m_ras.size() == 4) || ras_empty !== (m_ras.size() == 0) ||
                ras_ovf !== m_ovf || ras_unf !== m_unf) begin
                n_fail++;
                $display("FAIL random[%0d]: pc=%h cnt=%0d f=%b e=%b o=%b u=%b expected pc=%h cnt=%0d o=%b u=%b",
                         i, pc, ras_count, ras_full, ras_empty, ras_ovf, ras_unf,
                         m_pc, m_ras.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; stall = 1'b0; cmd = 3'd0;
        target = 12'h0; offset = 8'h0; err_clr = 1'b0;
        m_pc = 12'h0; m_ovf = 1'b0; m_unf = 1'b0;
        test_reset();
        test_next_stall();
        test_wrap_branch();
        test_call_ret();
        test_overflow();
        test_errclr();
        test_midchain_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the processor fetch stage. It extends the plain stall/load PC with:
- sequential increment
- absolute jump and PC-relative branch
- call/return through an internal return-address stack (RAS), with overflow/underflow reporting

It drives the instruction-memory address and takes its next-PC command from the decode/hazard logic.

## Interface
Parameters:
- ADDR_W, 12, PC and address width
- OFF_W, 8, branch offset width (two's complement), OFF_W ≤ ADDR_W
- STEP, 1, increment added for NEXT, CALL return address and RET-on-empty
- RAS_DEPTH, 4, return-address stack entries, ≥ 2
- RESET_VEC, 0, PC value after reset

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hold PC and RAS; command ignored
- cmd  in  3  next-PC command: NEXT=0, JUMP=1, BRANCH=2, CALL=3, RET=4; codes 5–7 = HOLD
- target  in  ADDR_W  absolute destination for JUMP/CALL
- offset  in  OFF_W  signed displacement for BRANCH
- err_clr  in  1  clears sticky error flags
- pc  out  ADDR_W  current program counter (registered)
- ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries
- ras_full  out  1  ras_count == RAS_DEPTH
- ras_empty  out  1  ras_count == 0
- ras_ovf  out  1  sticky: CALL executed while full
- ras_unf  out  1  sticky: RET executed while empty

## Operation
- Reset (rst_n=0 at a clk edge) sets:
  - pc=RESET_VEC, ras_count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0
  - RAS contents are don't-care
- Reset overrides stall and cmd.
- Priority order: reset > stall > cmd.
- stall=1: pc, RAS contents, ras_count and error flags (except err_clr) are unchanged.
- All PC arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- NEXT: pc ← pc+STEP.
- JUMP: pc ← target.
- BRANCH: pc ← pc + sign_extend(offset). Offset is relative to the current pc, not pc+STEP.
- CALL: push pc+STEP, then pc ← target.
  - If not full: ras_count increments.
  - If full: the oldest entry is discarded (circular overwrite), ras_count stays RAS_DEPTH, ras_ovf ← 1. The jump still happens.
- RET:
  - Not empty: pc ← top entry, ras_count decrements.
  - Empty: pc ← pc+STEP, ras_unf ← 1, ras_count stays 0.
- HOLD codes: pc and RAS unchanged, no error.
- err_clr=1 clears ras_ovf/ras_unf unless an error event occurs in the same cycle; in that case the flag is set (set wins). err_clr works during stall.
- The RAS is LIFO. After an overflow, the most recent RAS_DEPTH return addresses remain in correct order.

## Timing
- All state updates on the rising clk edge. No combinational path from inputs to outputs.
- Command latency is one cycle: a cmd sampled at edge N is visible on pc after edge N.
- A RET immediately after a CALL (back-to-back cycles) returns the address pushed by that CALL; no bubble is required.
- ras_count, ras_full, ras_empty and the error flags update on the same edge as the pc they relate to.
- Stall released: the command present in the first non-stalled cycle executes.
- Reset asserted mid-sequence (for example during a CALL chain) discards the entire stack on that edge.

## Structure
- Shared package pc_pkg holds:
  - command encoding constants (CMD_NEXT, CMD_JUMP, CMD_BRANCH, CMD_CALL, CMD_RET)
  - the command field width (3)
- Sub-module pc_ras implements the return-address stack:
  - circular buffer of RAS_DEPTH × ADDR_W
  - top pointer and count
  - push/pop ports, with full/empty outputs and overflow/underflow event outputs
- pc_sequencer owns the PC register, next-PC mux, sign extension, sticky flags and err_clr logic.

## Test plan
Defaults unless stated: ADDR_W=12, STEP=1, RAS_DEPTH=4, RESET_VEC=0.
- Reset then NEXT ×3 → pc 0,1,2,3. Assert stall for 2 cycles → pc holds 3. Release with NEXT → pc=4.
- JUMP target=0xFFE, then NEXT ×3 → pc 0xFFE,0xFFF,0x000,0x001 (wrap). Then BRANCH offset=0xFE (−2) → pc=0xFFF.
- From pc=0x010: CALL 0x100, CALL 0x200, RET, RET →
  - pc: 0x100, 0x200, 0x101, 0x011
  - ras_count: 1, 2, 1, 0; ras_empty=1 at end
- Five CALLs (targets 0x10, 0x20, 0x30, 0x40, 0x50, starting pc=0) → ras_ovf=1, ras_count=4. Then five RETs →
  - pc: 0x41, 0x31, 0x21, 0x11
  - fifth RET → pc=0x12, ras_unf=1
- RET while empty with err_clr=1 in the same cycle → ras_unf=1. err_clr alone on the next cycle → ras_unf=0.
- Mid-chain reset: two CALLs, then rst_n=0 for one cycle together with cmd=CALL → pc=RESET_VEC, ras_count=0, flags clear. A following RET underflows.
